// File: rtl/risc_pkg.sv
// Shared types and encodings for the multicycle RISC controller:
// state enum, datapath select codes, branch condition codes and the condition evaluator.
package risc_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
    S_WR_IMM, S_RD_RN, S_RD_RM, S_RD_RD, S_EXE, S_EXE_UN, S_WB, S_CMP_S,
    S_ADDR, S_LATCH_A, S_LD_MEM, S_LD_WB, S_PASS_B, S_ST_MEM,
    S_CHK, S_LINK, S_BR_CALC, S_BR_LD, S_HALT
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_MDATA = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  localparam logic [1:0] ASEL_A    = 2'b00;
  localparam logic [1:0] ASEL_ZERO = 2'b01;
  localparam logic [1:0] ASEL_PC   = 2'b10;

  localparam logic [1:0] BSEL_B    = 2'b00;
  localparam logic [1:0] BSEL_IMM5 = 2'b01;
  localparam logic [1:0] BSEL_IMM8 = 2'b10;

  localparam logic [1:0] SELPC_ZERO = 2'b00;
  localparam logic [1:0] SELPC_INC  = 2'b01;
  localparam logic [1:0] SELPC_C    = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;
  localparam logic [2:0] COND_GE = 3'b101;
  localparam logic [2:0] COND_GT = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // {opcode, op} encodings
  localparam logic [4:0] INS_MOV_IMM = 5'b11010;
  localparam logic [4:0] INS_MOV     = 5'b11000;
  localparam logic [4:0] INS_MVN     = 5'b10111;
  localparam logic [4:0] INS_ADD     = 5'b10100;
  localparam logic [4:0] INS_AND     = 5'b10110;
  localparam logic [4:0] INS_CMP     = 5'b10101;
  localparam logic [4:0] INS_LDR     = 5'b01100;
  localparam logic [4:0] INS_STR     = 5'b10000;
  localparam logic [4:0] INS_BL      = 5'b01011;
  localparam logic [4:0] INS_BX      = 5'b01000;
  localparam logic [4:0] INS_BLX     = 5'b01010;

  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  function automatic logic cond_taken(input logic [2:0] cond, input logic Z,
                                      input logic N, input logic V);
    logic lt;
    lt = N ^ V;
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return Z;
      COND_NE: return ~Z;
      COND_LT: return lt;
      COND_LE: return lt | Z;
      COND_GE: return ~lt;
      COND_GT: return ~lt & ~Z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Decides when the current memory access is complete: either after MEM_LAT cycles
// in a wait state, or when mem_ack is seen while waiting.
module mem_wait_timer #(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter int MEM_LAT       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic mem_ack,
  output logic done
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_reg;

  // mem_ack only counts while a wait state is active
  assign done = busy & (MEM_HANDSHAKE ? mem_ack : (cnt_reg == LAST));

  // Counter restarts on every wait-state exit so back-to-back accesses each get full latency
  always_ff @(posedge clk) begin
    if (rst || !busy || done)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multicycle control FSM for the simple RISC datapath: fetch/decode/execute sequencing,
// variable-latency memory waits, branch condition evaluation and a retired-instruction counter.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter int MEM_LAT       = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  input  logic [2:0]       cond,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             mem_ack,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_addr,
  output logic             addr_sel,
  output logic [2:0]       nsel,
  output logic [1:0]       vsel,
  output logic [1:0]       asel,
  output logic [1:0]       bsel,
  output logic [1:0]       sel_pc,
  output logic [1:0]       mem_cmd,
  output logic             w,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic [4:0]       code;
  logic             mem_busy, mem_done;

  assign code      = {opcode, op};
  assign mem_busy  = (state_reg == S_IF1) || (state_reg == S_LD_MEM) || (state_reg == S_ST_MEM);
  assign instr_cnt = instr_cnt_reg;

  mem_wait_timer #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .MEM_LAT      (MEM_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .busy   (mem_busy),
    .mem_ack(mem_ack),
    .done   (mem_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RESET;
      instr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE && instr_cnt_reg != '1)
        instr_cnt_reg <= instr_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    load_addr  = 1'b0;
    addr_sel   = 1'b0;
    nsel       = NSEL_NONE;
    vsel       = VSEL_C;
    asel       = ASEL_A;
    bsel       = BSEL_B;
    sel_pc     = SELPC_ZERO;
    mem_cmd    = MEM_NONE;
    w          = 1'b0;

    case (state_reg)
      S_RESET: begin
        load_pc    = 1'b1;
        sel_pc     = SELPC_ZERO;
        state_next = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        if (mem_done) state_next = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        load_ir    = 1'b1;
        state_next = S_UPD_PC;
      end
      S_UPD_PC: begin
        load_pc    = 1'b1;
        sel_pc     = SELPC_INC;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (code)
          INS_MOV_IMM:                                    state_next = S_WR_IMM;
          INS_MOV, INS_MVN:                               state_next = S_RD_RM;
          INS_ADD, INS_AND, INS_CMP, INS_LDR, INS_STR:    state_next = S_RD_RN;
          INS_BL, INS_BLX:                                state_next = S_LINK;
          INS_BX:                                         state_next = S_RD_RD;
          default: begin
            if (opcode == OPC_BRANCH)    state_next = S_CHK;
            else if (opcode == OPC_HALT) state_next = S_HALT;
            else                         state_next = S_IF1;
          end
        endcase
      end
      S_WR_IMM: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_IMM8;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_RD_RN: begin
        nsel       = NSEL_RN;
        loada      = 1'b1;
        state_next = (code == INS_LDR || code == INS_STR) ? S_ADDR : S_RD_RM;
      end
      S_RD_RM: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
        if (code == INS_MOV || code == INS_MVN) state_next = S_EXE_UN;
        else if (code == INS_CMP)               state_next = S_CMP_S;
        else                                    state_next = S_EXE;
      end
      S_EXE: begin
        asel       = ASEL_A;
        loadc      = 1'b1;
        state_next = S_WB;
      end
      // single-operand ops route zero into the A side of the ALU
      S_EXE_UN: begin
        asel       = ASEL_ZERO;
        loadc      = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        nsel       = NSEL_RD;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_CMP_S: begin
        asel       = ASEL_A;
        loads      = 1'b1;
        state_next = S_IF1;
      end
      S_ADDR: begin
        bsel       = BSEL_IMM5;
        loadc      = 1'b1;
        state_next = S_LATCH_A;
      end
      S_LATCH_A: begin
        load_addr  = 1'b1;
        state_next = (code == INS_LDR) ? S_LD_MEM : S_RD_RD;
      end
      S_LD_MEM: begin
        mem_cmd = MEM_READ;
        if (mem_done) state_next = S_LD_WB;
      end
      S_LD_WB: begin
        nsel       = NSEL_RD;
        vsel       = VSEL_MDATA;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_RD_RD: begin
        nsel       = NSEL_RD;
        loadb      = 1'b1;
        state_next = S_PASS_B;
      end
      S_PASS_B: begin
        asel       = ASEL_ZERO;
        loadc      = 1'b1;
        state_next = (code == INS_STR) ? S_ST_MEM : S_BR_LD;
      end
      S_ST_MEM: begin
        mem_cmd = MEM_WRITE;
        if (mem_done) state_next = S_IF1;
      end
      S_CHK: begin
        state_next = cond_taken(cond, Z, N, V) ? S_BR_CALC : S_IF1;
      end
      // PC already points past this instruction, so it is the link value
      S_LINK: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_PC;
        write      = 1'b1;
        state_next = (code == INS_BL) ? S_BR_CALC : S_RD_RD;
      end
      S_BR_CALC: begin
        asel       = ASEL_PC;
        bsel       = BSEL_IMM8;
        loadc      = 1'b1;
        state_next = S_BR_LD;
      end
      S_BR_LD: begin
        load_pc    = 1'b1;
        sel_pc     = SELPC_C;
        state_next = S_IF1;
      end
      S_HALT: begin
        w = 1'b1;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Bench for risc_ctrl_fsm: a fixed-latency instance (MEM_LAT=3) and a handshake instance
// (CNT_W=2) checked cycle by cycle against per-instruction micro-step sequences.
module tb_risc_ctrl_fsm;

  typedef struct packed {
    logic       loada, loadb, loadc, loads, write, load_pc, load_ir, load_addr, addr_sel;
    logic [2:0] nsel;
    logic [1:0] vsel, asel, bsel, sel_pc, mem_cmd;
    logic       w;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_s [2];
  logic [2:0] opc_s [2];
  logic [1:0] op_s  [2];
  logic [2:0] cond_s[2];
  logic       zf[2], nf[2], vf[2], ack_s[2];
  wire [22:0] ov0, ov1;
  wire [15:0] cnt0;
  wire [1:0]  cnt1;

  int checks = 0;
  int errors = 0;
  int cnt_model[2];
  string steps[$];

  always #5 clk = ~clk;

  risc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .MEM_LAT(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst_s[0]), .opcode(opc_s[0]), .op(op_s[0]), .cond(cond_s[0]),
    .Z(zf[0]), .N(nf[0]), .V(vf[0]), .mem_ack(ack_s[0]),
    .loada(ov0[22]), .loadb(ov0[21]), .loadc(ov0[20]), .loads(ov0[19]), .write(ov0[18]),
    .load_pc(ov0[17]), .load_ir(ov0[16]), .load_addr(ov0[15]), .addr_sel(ov0[14]),
    .nsel(ov0[13:11]), .vsel(ov0[10:9]), .asel(ov0[8:7]), .bsel(ov0[6:5]),
    .sel_pc(ov0[4:3]), .mem_cmd(ov0[2:1]), .w(ov0[0]), .instr_cnt(cnt0));

  risc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .MEM_LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst_s[1]), .opcode(opc_s[1]), .op(op_s[1]), .cond(cond_s[1]),
    .Z(zf[1]), .N(nf[1]), .V(vf[1]), .mem_ack(ack_s[1]),
    .loada(ov1[22]), .loadb(ov1[21]), .loadc(ov1[20]), .loads(ov1[19]), .write(ov1[18]),
    .load_pc(ov1[17]), .load_ir(ov1[16]), .load_addr(ov1[15]), .addr_sel(ov1[14]),
    .nsel(ov1[13:11]), .vsel(ov1[10:9]), .asel(ov1[8:7]), .bsel(ov1[6:5]),
    .sel_pc(ov1[4:3]), .mem_cmd(ov1[2:1]), .w(ov1[0]), .instr_cnt(cnt1));

  function automatic ov_t cur_ov(input int d);
    return (d == 0) ? ov_t'(ov0) : ov_t'(ov1);
  endfunction

  function automatic int cur_cnt(input int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  // Datapath actions of each micro-step, as listed in the controller description
  function automatic ov_t exp_vec(input string s);
    ov_t o = '0;
    case (s)
      "RESET":   begin o.load_pc = 1; o.sel_pc = 2'b00; end
      "IF1":     begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
      "IF2":     begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
      "UPD_PC":  begin o.load_pc = 1; o.sel_pc = 2'b01; end
      "WR_IMM":  begin o.nsel = 3'b001; o.vsel = 2'b10; o.write = 1; end
      "RD_RN":   begin o.nsel = 3'b001; o.loada = 1; end
      "RD_RM":   begin o.nsel = 3'b100; o.loadb = 1; end
      "RD_RD":   begin o.nsel = 3'b010; o.loadb = 1; end
      "EXE":     begin o.asel = 2'b00; o.loadc = 1; end
      "EXE_UN":  begin o.asel = 2'b01; o.loadc = 1; end
      "WB":      begin o.nsel = 3'b010; o.vsel = 2'b00; o.write = 1; end
      "CMP_S":   begin o.asel = 2'b00; o.loads = 1; end
      "ADDR":    begin o.bsel = 2'b01; o.loadc = 1; end
      "LATCH_A": begin o.load_addr = 1; end
      "LD_MEM":  begin o.mem_cmd = 2'b01; end
      "LD_WB":   begin o.nsel = 3'b010; o.vsel = 2'b01; o.write = 1; end
      "PASS_B":  begin o.asel = 2'b01; o.loadc = 1; end
      "ST_MEM":  begin o.mem_cmd = 2'b10; end
      "LINK":    begin o.nsel = 3'b001; o.vsel = 2'b11; o.write = 1; end
      "BR_CALC": begin o.asel = 2'b10; o.bsel = 2'b10; o.loadc = 1; end
      "BR_LD":   begin o.load_pc = 1; o.sel_pc = 2'b10; end
      "HALT":    begin o.w = 1; end
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic bit br_taken(input logic [2:0] cc, input bit z, input bit n, input bit v);
    bit lt = (n != v);
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return lt;
      3'd4: return lt || z;
      3'd5: return !lt;
      3'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void build(input logic [4:0] code, input logic [2:0] cc,
                                input bit z, input bit n, input bit v);
    steps = {"IF1", "IF2", "UPD_PC", "DECODE"};
    case (code)
      5'b11010: steps.push_back("WR_IMM");
      5'b11000, 5'b10111: steps = {steps, "RD_RM", "EXE_UN", "WB"};
      5'b10100, 5'b10110: steps = {steps, "RD_RN", "RD_RM", "EXE", "WB"};
      5'b10101: steps = {steps, "RD_RN", "RD_RM", "CMP_S"};
      5'b01100: steps = {steps, "RD_RN", "ADDR", "LATCH_A", "LD_MEM", "LD_WB"};
      5'b10000: steps = {steps, "RD_RN", "ADDR", "LATCH_A", "RD_RD", "PASS_B", "ST_MEM"};
      5'b01011: steps = {steps, "LINK", "BR_CALC", "BR_LD"};
      5'b01000: steps = {steps, "RD_RD", "PASS_B", "BR_LD"};
      5'b01010: steps = {steps, "LINK", "RD_RD", "PASS_B", "BR_LD"};
      default: begin
        if (code[4:2] == 3'b001) begin
          steps.push_back("CHK");
          if (br_taken(cc, z, n, v)) steps = {steps, "BR_CALC", "BR_LD"};
        end else if (code[4:2] == 3'b111) begin
          steps = {steps, "HALT", "HALT", "HALT", "HALT"};
        end
      end
    endcase
  endfunction

  // Drive one instruction and compare every cycle; kf/kd = mem_ack low cycles for fetch/data
  // (handshake instance). stop_after >= 0 abandons the instruction after that many cycles.
  task automatic run_instr(input int d, input logic [4:0] code, input logic [2:0] cc,
                           input bit z, input bit n, input bit v, input int kf, input int kd,
                           input int stop_after, input string tag);
    int cyc = 0;
    int nrep;
    bit is_mem;
    ov_t got, want;
    opc_s[d] = code[4:2]; op_s[d] = code[1:0]; cond_s[d] = cc;
    zf[d] = z; nf[d] = n; vf[d] = v;
    build(code, cc, z, n, v);
    foreach (steps[i]) begin
      is_mem = (steps[i] == "IF1") || (steps[i] == "LD_MEM") || (steps[i] == "ST_MEM");
      nrep = !is_mem ? 1 : (d == 0) ? 3 : ((steps[i] == "IF1") ? kf : kd) + 1;
      for (int r = 0; r < nrep; r++) begin
        if (stop_after >= 0 && cyc == stop_after) return;
        got  = cur_ov(d);
        want = exp_vec(steps[i]);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s dut%0d step %s cycle %0d: outputs %h, expected %h",
                   tag, d, steps[i], cyc, got, want);
        end
        if (steps[i] == "DECODE" && cnt_model[d] < cnt_max(d)) cnt_model[d]++;
        ack_s[d] = (is_mem && d == 1) ? (r == nrep - 1) : 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (cur_cnt(d) !== cnt_model[d]) begin
      errors++;
      $display("FAIL %s dut%0d instr_cnt: got %0d, expected %0d", tag, d, cur_cnt(d), cnt_model[d]);
    end
    $display("txn %s dut%0d code=%b cond=%b ZNV=%0d%0d%0d cycles=%0d cnt=%0d",
             tag, d, code, cc, z, n, v, cyc, cur_cnt(d));
  endtask

  task automatic do_reset(input int d);
    ov_t got;
    rst_s[d] = 1'b1;
    ack_s[d] = 1'b1;
    @(negedge clk);
    got = cur_ov(d);
    checks++;
    if (got !== exp_vec("RESET")) begin
      errors++;
      $display("FAIL reset dut%0d outputs: got %h, expected %h", d, got, exp_vec("RESET"));
    end
    checks++;
    if (cur_cnt(d) !== 0) begin
      errors++;
      $display("FAIL reset dut%0d instr_cnt: got %0d, expected 0", d, cur_cnt(d));
    end
    rst_s[d] = 1'b0;
    cnt_model[d] = 0;
    @(negedge clk);
    $display("txn reset dut%0d", d);
  endtask

  task automatic test_reset();
    do_reset(0);
    do_reset(1);
  endtask

  task automatic test_fixed_latency();
    do_reset(0);
    run_instr(0, 5'b11010, 3'b000, 0, 0, 0, 0, 0, -1, "mov_imm");
    run_instr(0, 5'b11100, 3'b000, 0, 0, 0, 0, 0, -1, "halt");
  endtask

  task automatic test_handshake_ldr();
    do_reset(1);
    run_instr(1, 5'b01100, 3'b000, 0, 0, 0, 2, 5, -1, "ldr_hs");
    run_instr(1, 5'b10000, 3'b000, 0, 0, 0, 0, 3, -1, "str_hs");
  endtask

  task automatic test_cond_codes();
    do_reset(0);
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        run_instr(0, {3'b001, 2'($urandom_range(0, 3))}, 3'(c), f[2], f[1], f[0], 0, 0, -1, "branch");
  endtask

  task automatic test_blx();
    run_instr(0, 5'b01010, 3'b000, 0, 0, 0, 0, 0, -1, "blx");
    run_instr(0, 5'b01011, 3'b000, 0, 0, 0, 0, 0, -1, "bl");
    run_instr(0, 5'b01000, 3'b000, 0, 0, 0, 0, 0, -1, "bx");
  endtask

  task automatic test_reset_mid_access();
    // 6 fetch/decode cycles + 5 STR steps, then 1 of 3 ST_MEM cycles
    run_instr(0, 5'b10000, 3'b000, 0, 0, 0, 0, 0, 12, "str_abort");
    do_reset(0);
    run_instr(0, 5'b11000, 3'b000, 0, 0, 0, 0, 0, -1, "mov_after_abort");
    do_reset(1);
    run_instr(1, 5'b01100, 3'b000, 0, 0, 0, 0, 10, 9, "ldr_abort");
    do_reset(1);
    run_instr(1, 5'b10100, 3'b000, 0, 0, 0, 2, 0, -1, "add_after_abort");
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 5; i++)
      run_instr(1, 5'b00000, 3'b000, 0, 0, 0, $urandom_range(0, 2), 0, -1, "nop_sat");
  endtask

  task automatic test_back_to_back();
    logic [4:0] valid_codes[12] = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101,
                                    5'b01100, 5'b10000, 5'b01011, 5'b01000, 5'b01010, 5'b00100};
    logic [4:0] code;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 4) != 0) code = valid_codes[$urandom_range(0, 11)];
        else code = 5'($urandom_range(0, 27));
        run_instr(d, code, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4), $urandom_range(0, 4), -1, "random");
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; opc_s[d] = '0; op_s[d] = '0; cond_s[d] = '0;
      zf[d] = 0; nf[d] = 0; vf[d] = 0; ack_s[d] = 0; cnt_model[d] = 0;
    end
    test_reset();
    test_fixed_latency();
    test_handshake_ldr();
    test_cond_codes();
    test_blx();
    test_reset_mid_access();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
